lsu_ram_master: RTL and testbench
=================================

# lsu_ram_master

Initiator side of the core's load/store memory port. Accepts one load or store request at a time from the mem stage and drives the RAM's split read/write channel (ren/raddr/rdata/rready, wen/waddr/wdata/wmask/wready/bvalid). It produces a single-cycle response carrying size-extended load data or store completion, and stalls the pipeline through `req_ready_o`. A bounded wait counter guarantees every accepted request eventually responds, even if the RAM never handshakes.

## Interface
- `ADDR_W`, 32: width of RAM address outputs; request address is truncated to this width.
- `TIMEOUT`, 15: maximum wait cycles in RD or WRESP before an error response; must be ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid_i`  in  1  request present from mem stage.
- `req_ready_o`  out  1  high only in IDLE; a request is accepted when valid & ready.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  64  byte address; misaligned allowed, since the RAM handles byte offsets.
- `req_wdata_i`  in  64  store data, LSB-aligned.
- `req_size_i`  in  2  0=byte, 1=half, 2=word, 3=double.
- `req_signed_i`  in  1  load sign-extends when 1, zero-extends when 0.
- `rsp_valid_o`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata_o`  out  64  extended load data; 0 for stores and on error.
- `rsp_err_o`  out  1  timeout occurred; valid with `rsp_valid_o`.
- `ram_ren_o`  out  1  read enable.
- `ram_raddr_o`  out  ADDR_W  read address.
- `ram_rdata_i`  in  64  read data, combinational from the RAM.
- `ram_rready_i`  in  1  read data valid this cycle.
- `ram_wen_o`  out  1  write enable.
- `ram_waddr_o`  out  ADDR_W  write address.
- `ram_wdata_o`  out  64  write data, pre-masked (`wdata & wmask`).
- `ram_wmask_o`  out  64  bit-granular write mask.
- `ram_wready_i`  in  1  RAM can take write this cycle.
- `ram_bvalid_i`  in  1  write completion, registered in the RAM one cycle after `wen`.

## Operation
- States: IDLE, RD, WR, WRESP, RSP.
- IDLE, on accept: latch addr, we, size, signed, and masked wdata; go to RD if load, WR if store.
- RD: `ram_ren_o`=1 and `ram_raddr_o`=latched addr.
  - If `ram_rready_i`: capture `ram_rdata_i`, then go to RSP.
- WR: `ram_wen_o`=1 with waddr, wdata and wmask.
  - If `ram_wready_i`: go to WRESP; `wen` is thus high for exactly one accepted cycle.
  - Otherwise hold in WR.
- WRESP: all RAM enables 0; on `ram_bvalid_i`, go to RSP.
- RSP: `rsp_valid_o`=1, then go to IDLE.
- Write mask by size: 0x00..FF, 0x00..FFFF, 0x0000_0000_FFFF_FFFF, all ones.
- Load extension: take the low 8/16/32/64 bits of the captured data and extend per `req_signed_i`; size 3 passes through unchanged.
- Wait counter:
  - Cleared on entering RD, WR or WRESP; increments each cycle spent waiting there.
  - When it reaches TIMEOUT: go to RSP with `rsp_err_o`=1 and `rsp_rdata_o`=0, dropping any enables.
- `req_valid_i` outside IDLE is ignored; the request must be held until accepted.
- Reset in any state: go to IDLE and discard the in-flight request; no response is ever issued for it.

## Timing
- Reset values: all outputs 0 except `req_ready_o`=1 (IDLE).
- Load with RAM always ready: accept at cycle 0, `ren` at cycle 1, `rsp_valid` at cycle 2.
- Store with RAM always ready: accept at cycle 0, `wen` at cycle 1, `bvalid` seen at cycle 2, `rsp_valid` at cycle 3.
- Next accept is possible in the cycle after RSP, so back-to-back throughput is one load per 3 cycles and one store per 4 cycles.
- `rsp_rdata_o` and `rsp_err_o` are registered and valid only while `rsp_valid_o`=1; otherwise 0.
- `bvalid` arriving while not in WRESP is ignored.

## Structure
- Shared package `lsu_ram_pkg` holds:
  - state enum;
  - size encodings (SZ_B/SZ_H/SZ_W/SZ_D);
  - functions `size_to_mask(size)` and `load_extend(data, size, signed)`.
- One natural sub-module: `lsu_data_align`, combinational mask generation and load extension. The FSM, latches and counter stay in the top.

## Test plan
- Load byte, addr 0x8000_0003, signed, rdata 0x...0000_0080 -> `rsp_valid` at cycle 2, `rsp_rdata`=0xFFFF_FFFF_FFFF_FF80, `rsp_err`=0.
- Store half, addr 0x100, wdata 0x1234_ABCD -> one-cycle `wen` with wmask=0xFFFF, wdata=0xABCD; `rsp_valid` at cycle 3.
- `ram_wready_i` low for 3 cycles -> `wen` held for 4 cycles, then WRESP entered; exactly one accepted write.
- `ram_rready_i` never asserted, TIMEOUT=15 -> `rsp_valid` with `rsp_err`=1 and rdata=0 exactly 15 cycles after RD entry; `ren` drops.
- `rst` pulsed in WRESP -> next cycle IDLE, `req_ready`=1, no `rsp_valid`; a later load completes normally.
- `req_valid` held high across a store -> second request accepted only in the cycle after RSP; `req_ready` low throughout.

Source files
------------

// File: rtl/lsu_ram_pkg.sv
// Shared state codes, access-size encodings and data helpers for the LSU RAM master.
package lsu_ram_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RD    = 3'd1;
  localparam state_t ST_WR    = 3'd2;
  localparam state_t ST_WRESP = 3'd3;
  localparam state_t ST_RSP   = 3'd4;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [63:0] size_to_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = '1;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] data, input logic [1:0] size,
                                              input logic sext);
    logic [63:0] r;
    case (size)
      SZ_B:    r = {{56{sext & data[7]}}, data[7:0]};
      SZ_H:    r = {{48{sext & data[15]}}, data[15:0]};
      SZ_W:    r = {{32{sext & data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational write-mask generation and load-data size extension.
module lsu_data_align
  import lsu_ram_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [63:0] rdata,
  output logic [63:0] wmask,
  output logic [63:0] rdata_ext
);

  assign wmask     = size_to_mask(size);
  assign rdata_ext = load_extend(rdata, size, sext);

endmodule

// File: rtl/lsu_ram_master.sv
// Single-outstanding load/store initiator onto a split read/write RAM channel,
// with a bounded wait so every accepted request produces exactly one response.
module lsu_ram_master
  import lsu_ram_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [63:0]       req_addr_i,
  input  logic [63:0]       req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  output logic              rsp_valid_o,
  output logic [63:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              ram_ren_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  input  logic [63:0]       ram_rdata_i,
  input  logic              ram_rready_i,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_waddr_o,
  output logic [63:0]       ram_wdata_o,
  output logic [63:0]       ram_wmask_o,
  input  logic              ram_wready_i,
  input  logic              ram_bvalid_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              timeout;
  logic [63:0]       wmask;
  logic [63:0]       rdata_ext;

  lsu_data_align u_align (
    .size      (size_q),
    .sext      (sext_q),
    .rdata     (ram_rdata_i),
    .wmask     (wmask),
    .rdata_ext (rdata_ext)
  );

  // The cycle that would be the TIMEOUT-th wait gives up instead of counting on.
  assign timeout = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= SZ_B;
      sext_q   <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            addr_q   <= req_addr_i[ADDR_W-1:0];
            wdata_q  <= req_wdata_i & size_to_mask(req_size_i);
            size_q   <= req_size_i;
            sext_q   <= req_signed_i;
            wait_cnt <= '0;
            state    <= req_we_i ? ST_WR : ST_RD;
          end
        end
        ST_RD: begin
          if (ram_rready_i) begin
            rdata_q <= rdata_ext;
            err_q   <= 1'b0;
            state   <= ST_RSP;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RSP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WR: begin
          if (ram_wready_i) begin
            wait_cnt <= '0;
            state    <= ST_WRESP;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RSP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WRESP: begin
          if (ram_bvalid_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state   <= ST_RSP;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RSP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RSP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_RSP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // RAM-side buses are zeroed whenever their enable is low.
  assign ram_ren_o   = (state == ST_RD);
  assign ram_raddr_o = ram_ren_o ? addr_q : '0;
  assign ram_wen_o   = (state == ST_WR);
  assign ram_waddr_o = ram_wen_o ? addr_q : '0;
  assign ram_wdata_o = ram_wen_o ? wdata_q : '0;
  assign ram_wmask_o = ram_wen_o ? wmask : '0;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Scoreboard bench: expected responses are queued at request time and checked on rsp_valid.
module tb_lsu_ram_master;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [63:0]       req_addr = '0;
  logic [63:0]       req_wdata = '0;
  logic [1:0]        req_size = '0;
  logic              req_signed = 1'b0;
  logic              rsp_valid;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;
  logic              ram_ren;
  logic [ADDR_W-1:0] ram_raddr;
  logic [63:0]       ram_rdata = '0;
  logic              ram_rready = 1'b0;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_waddr;
  logic [63:0]       ram_wdata;
  logic [63:0]       ram_wmask;
  logic              ram_wready = 1'b0;
  logic              ram_bvalid = 1'b0;

  logic bv_en = 1'b1;
  int   wr_acc = 0;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  lsu_ram_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_size_i   (req_size),
    .req_signed_i (req_signed),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .ram_ren_o    (ram_ren),
    .ram_raddr_o  (ram_raddr),
    .ram_rdata_i  (ram_rdata),
    .ram_rready_i (ram_rready),
    .ram_wen_o    (ram_wen),
    .ram_waddr_o  (ram_waddr),
    .ram_wdata_o  (ram_wdata),
    .ram_wmask_o  (ram_wmask),
    .ram_wready_i (ram_wready),
    .ram_bvalid_i (ram_bvalid)
  );

  // RAM write channel: completion registered one cycle after an accepted write.
  always @(posedge clk) begin
    ram_bvalid <= bv_en & ram_wen & ram_wready & ~rst;
    if (ram_wen & ram_wready) wr_acc <= wr_acc + 1;
  end

  function automatic logic [63:0] exp_ext(input logic [63:0] d, input int sz, input bit s);
    logic [63:0] r;
    case (sz)
      0: r = s ? 64'($signed(d[7:0]))  : 64'(d[7:0]);
      1: r = s ? 64'($signed(d[15:0])) : 64'(d[15:0]);
      2: r = s ? 64'($signed(d[31:0])) : 64'(d[31:0]);
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for it to be accepted, then drop valid; returns in cycle 1.
  task automatic issue(input logic we, input logic [63:0] a, input logic [63:0] wd,
                       input logic [1:0] sz, input logic s);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    req_size = sz; req_signed = s;
    while (!req_ready && n < 50) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin tick(); lat++; end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    n_cmp++;
    if ({rsp_valid, rsp_err, ram_ren, ram_wen} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctl got=%b want=0000", {rsp_valid, rsp_err, ram_ren, ram_wen});
    end
    n_cmp++;
    if ({rsp_rdata, ram_wdata, ram_wmask} !== '0 || ram_raddr !== '0 || ram_waddr !== '0) begin
      n_bad++; $display("FAIL reset_data got rdata=%h wdata=%h wmask=%h want=0", rsp_rdata, ram_wdata, ram_wmask);
    end
  endtask

  task automatic test_load_byte();
    int lat;
    rsp_t e;
    ram_rready = 1'b1;
    ram_rdata = 64'h1234_5678_0000_0080;
    exp_q.push_back('{rdata: 64'hFFFF_FFFF_FFFF_FF80, err: 1'b0});
    issue(1'b0, 64'h8000_0003, 64'h0, 2'd0, 1'b1);
    n_cmp++;
    if (ram_ren !== 1'b1 || ram_raddr !== 32'h8000_0003) begin
      n_bad++; $display("FAIL ld_ren got ren=%b raddr=%h want 1/80000003", ram_ren, ram_raddr);
    end
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL ld_latency got=%0d want=1", lat); end
    if (lat >= 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_bad++; $display("FAIL ld_byte_data got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
      n_bad++; $display("FAIL ld_pulse got valid=%b rdata=%h want 0/0", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_load_sizes();
    int lat;
    rsp_t e;
    ram_rready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ram_rdata = {$urandom, $urandom} | 64'h0000_0000_8000_8080;
      exp_q.push_back('{rdata: exp_ext(ram_rdata, i % 4, i >= 4), err: 1'b0});
      issue(1'b0, 64'h40 + 64'(i), 64'h0, 2'(i % 4), i >= 4);
      wait_rsp(lat);
      if (lat >= 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          n_bad++; $display("FAIL ld_size%0d_s%0d got=%h/%b want=%h/%b", i % 4, i >= 4, rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end else begin
        n_cmp++; n_bad++; $display("FAIL ld_size_timeout got=none want=rsp");
      end
      tick();
    end
  endtask

  task automatic test_store_half();
    int lat, acc0;
    rsp_t e;
    ram_wready = 1'b1; bv_en = 1'b1;
    acc0 = wr_acc;
    exp_q.push_back('{rdata: 64'h0, err: 1'b0});
    issue(1'b1, 64'h100, 64'h1234_ABCD, 2'd1, 1'b0);
    n_cmp++;
    if (ram_wen !== 1'b1 || ram_waddr !== 32'h100 || ram_wmask !== 64'hFFFF || ram_wdata !== 64'hABCD) begin
      n_bad++; $display("FAIL st_half_wr got wen=%b waddr=%h wmask=%h wdata=%h want 1/100/ffff/abcd", ram_wen, ram_waddr, ram_wmask, ram_wdata);
    end
    tick();
    n_cmp++;
    if (ram_wen !== 1'b0) begin n_bad++; $display("FAIL st_wen_pulse got=%b want=0", ram_wen); end
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL st_latency got=%0d want=1 (rsp at cycle 3)", lat); end
    if (lat >= 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_bad++; $display("FAIL st_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    n_cmp++;
    if (wr_acc - acc0 !== 1) begin n_bad++; $display("FAIL st_accepts got=%0d want=1", wr_acc - acc0); end
    tick();
  endtask

  task automatic test_wready_stall();
    int lat, acc0, wen_cyc;
    rsp_t e;
    ram_wready = 1'b0; bv_en = 1'b1;
    acc0 = wr_acc; wen_cyc = 0;
    exp_q.push_back('{rdata: 64'h0, err: 1'b0});
    issue(1'b1, 64'h208, 64'hDEAD_BEEF_CAFE_F00D, 2'd2, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (ram_wen) wen_cyc++;
      if (k == 4) ram_wready = 1'b1;
      tick();
    end
    n_cmp++;
    if (wen_cyc !== 4) begin n_bad++; $display("FAIL stall_wen_cycles got=%0d want=4", wen_cyc); end
    n_cmp++;
    if (wr_acc - acc0 !== 1) begin n_bad++; $display("FAIL stall_accepts got=%0d want=1", wr_acc - acc0); end
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 0) begin n_bad++; $display("FAIL stall_latency got=%0d want=0", lat); end
    if (lat >= 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_bad++; $display("FAIL stall_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    int lat;
    rsp_t e;
    ram_rready = 1'b0;
    ram_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
    exp_q.push_back('{rdata: 64'h0, err: 1'b1});
    issue(1'b0, 64'h300, 64'h0, 2'd3, 1'b0);
    wait_rsp(lat);
    n_cmp++;
    if (lat !== TIMEOUT) begin n_bad++; $display("FAIL to_latency got=%0d want=%0d", lat, TIMEOUT); end
    n_cmp++;
    if (ram_ren !== 1'b0) begin n_bad++; $display("FAIL to_ren_drop got=%b want=0", ram_ren); end
    if (lat >= 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_bad++; $display("FAIL to_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    tick();
    ram_rready = 1'b1;
  endtask

  task automatic test_reset_in_wresp();
    int lat, spurious;
    rsp_t e;
    ram_wready = 1'b1; bv_en = 1'b0;
    issue(1'b1, 64'h400, 64'h1, 2'd0, 1'b0);
    tick(); tick();
    n_cmp++;
    if (req_ready !== 1'b0 || ram_wen !== 1'b0) begin
      n_bad++; $display("FAIL wresp_state got ready=%b wen=%b want 0/0", req_ready, ram_wen);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bv_en = 1'b1;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_wresp got ready=%b rsp=%b want 1/0", req_ready, rsp_valid);
    end
    spurious = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid) spurious++;
      tick();
    end
    n_cmp++;
    if (spurious !== 0) begin n_bad++; $display("FAIL rst_no_rsp got=%0d want=0", spurious); end
    ram_rready = 1'b1;
    ram_rdata = 64'h0000_0000_0000_8001;
    exp_q.push_back('{rdata: 64'hFFFF_FFFF_FFFF_8001, err: 1'b0});
    issue(1'b0, 64'h500, 64'h0, 2'd1, 1'b1);
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL post_rst_latency got=%0d want=1", lat); end
    if (lat >= 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_bad++; $display("FAIL post_rst_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, acc0, bad;
    rsp_t e;
    ram_wready = 1'b1; ram_rready = 1'b1; bv_en = 1'b1;
    acc0 = wr_acc; bad = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h600; req_wdata = 64'h0102_0304_0506_0708;
    req_size = 2'd3; req_signed = 1'b0;
    exp_q.push_back('{rdata: 64'h0, err: 1'b0});
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (req_ready !== 1'b0) bad++;
      if (c == 3) begin
        n_cmp++;
        if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_rsp_cycle got=%b want=1", rsp_valid); end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp++;
          if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            n_bad++; $display("FAIL b2b_st_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
          end
        end
      end
      tick();
    end
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL b2b_ready_low got=%0d high cycles want=0", bad); end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after got=%b want=1", req_ready); end
    req_we = 1'b0; req_addr = 64'h700; req_size = 2'd2; req_signed = 1'b0;
    ram_rdata = 64'hFFFF_FFFF_8765_4321;
    exp_q.push_back('{rdata: 64'h0000_0000_8765_4321, err: 1'b0});
    tick();
    req_valid = 1'b0;
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL b2b_ld_latency got=%0d want=1", lat); end
    if (lat >= 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_bad++; $display("FAIL b2b_ld_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    n_cmp++;
    if (wr_acc - acc0 !== 1) begin n_bad++; $display("FAIL b2b_accepts got=%0d want=1", wr_acc - acc0); end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_bad++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_sizes();
    test_store_half();
    test_wready_stall();
    test_timeout();
    test_reset_in_wresp();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
